// File: rtl/shift_seq.sv
// Multi-cycle barrel shifter: one fixed power-of-two stage per clock,
// MSB stage first, giving a constant latency for every shift amount.
module shift_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       mode_q, mode_d;
  logic [SHW-1:0]   k_q, k_d;
  logic [SHW-1:0]   step;
  logic [WIDTH-1:0] shifted;

  // Distance of the current stage is 2^k; it always fits in SHW bits.
  always_comb begin
    step = SHW'(1) << k_q;
    case (mode_q)
      2'b00:   shifted = work_q >> step;
      2'b01:   shifted = work_q << step;
      2'b10:   shifted = $unsigned($signed(work_q) >>> step);
      default: shifted = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    shamt_d  = shamt_q;
    mode_d   = mode_q;
    k_d      = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = a;
          shamt_d = shamt;
          mode_d  = mode;
          k_d     = SHW'(SHW - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shamt_q[k_q]) begin
          work_d = shifted;
        end
        k_d = k_q - 1'b1;
        // Last stage: reserved mode is forced to zero whatever shamt was.
        if (k_q == '0) begin
          if (mode_q == 2'b11) begin
            work_d = '0;
          end
          result_d = work_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      shamt_q  <= '0;
      mode_q   <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      shamt_q  <= shamt_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == SHIFT) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed cases plus randomized operations
// compared against a one-line-per-mode shift reference.
module tb_shift_seq;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic [1:0]       mode;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int checkCount;
  int passCount;
  logic [WIDTH-1:0] expResult;

  shift_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .shamt(shamt),
    .mode(mode),
    .ready(ready),
    .busy(busy),
    .done(done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] refShift(input logic [WIDTH-1:0] v,
                                                input logic [SHW-1:0] s,
                                                input logic [1:0] m);
    case (m)
      2'b00:   return v >> s;
      2'b01:   return v << s;
      2'b10:   return $unsigned($signed(v) >>> s);
      default: return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation from IDLE; with noisy set, inputs and start are
  // scrambled every cycle while the operation is in flight.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [SHW-1:0] sv,
                               input logic [1:0] mv, input bit noisy);
    int cyc;
    logic [WIDTH-1:0] want;
    want = refShift(av, sv, mv);
    checkOutput("ready_idle", 32'(ready), 32'd1);
    start = 1'b1;
    a = av;
    shamt = sv;
    mode = mv;
    step();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (cyc == 2) begin
        checkOutput("busy_mid", 32'({ready, busy}), 32'b01);
        checkOutput("result_hold", result, expResult);
      end
      if (noisy) begin
        a = $urandom;
        shamt = SHW'($urandom);
        mode = 2'($urandom);
        start = 1'($urandom);
      end
      step();
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'd5);
    checkOutput("result", result, want);
    expResult = want;
    start = 1'b0;
    step();
    checkOutput("done_single", 32'({done, ready, busy}), 32'b010);
    checkOutput("result_after", result, expResult);
  endtask

  initial begin
    int cyc;
    bit sawDone;
    logic [WIDTH-1:0] secondA;
    checkCount = 0;
    passCount = 0;
    expResult = '0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    shamt = '0;
    mode = '0;
    step();
    step();
    checkOutput("reset_state", 32'({ready, busy, done}), 32'b100);
    checkOutput("reset_result", result, 32'd0);
    rst = 1'b0;

    applyStimulus(32'h8000_0001, 5'd4, 2'b00, 1'b0);
    checkOutput("dir_lsr", result, 32'h0800_0000);
    applyStimulus(32'hF000_0000, 5'd4, 2'b10, 1'b0);
    checkOutput("dir_asr4", result, 32'hFF00_0000);
    applyStimulus(32'h8000_0000, 5'd31, 2'b10, 1'b0);
    checkOutput("dir_asr31", result, 32'hFFFF_FFFF);
    applyStimulus(32'h0000_0001, 5'd31, 2'b01, 1'b0);
    checkOutput("dir_lsl31", result, 32'h8000_0000);
    applyStimulus(32'h1234_5678, 5'd0, 2'b00, 1'b0);
    checkOutput("dir_zero", result, 32'h1234_5678);
    applyStimulus(32'hFFFF_FFFF, 5'd3, 2'b11, 1'b0);
    checkOutput("dir_reserved", result, 32'h0000_0000);

    // Start held high every cycle with a changing operand.
    start = 1'b1;
    a = 32'hA5A5_0F0F;
    shamt = 5'd8;
    mode = 2'b00;
    step();
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      a = $urandom;
      step();
      cyc++;
    end
    checkOutput("b2b_latency", 32'(cyc), 32'd6);
    checkOutput("b2b_first", result, refShift(32'hA5A5_0F0F, 5'd8, 2'b00));
    a = $urandom;
    step();
    checkOutput("b2b_ready7", 32'(ready), 32'd1);
    secondA = $urandom;
    a = secondA;
    step();
    checkOutput("b2b_reaccept", 32'({ready, busy}), 32'b01);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    checkOutput("b2b_second", result, refShift(secondA, 5'd8, 2'b00));
    expResult = refShift(secondA, 5'd8, 2'b00);
    step();

    // Reset asserted during the third SHIFT cycle.
    start = 1'b1;
    a = 32'hDEAD_BEEF;
    shamt = 5'd1;
    mode = 2'b01;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort_state", 32'({ready, busy, done}), 32'b100);
    checkOutput("abort_result", result, 32'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) sawDone = 1'b1;
      step();
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);
    expResult = '0;

    // Start coinciding with reset is dropped.
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    step();
    checkOutput("rst_start_drop", 32'({ready, busy}), 32'b10);

    for (int i = 0; i < 30; i++) begin
      applyStimulus($urandom, SHW'($urandom), 2'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width.
REQ-002 The block SHALL have parameter SHW, default 5, giving the shift-amount width; WIDTH SHALL equal 2^SHW.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to begin a shift; sampled only while ready=1.
REQ-006 a  input  WIDTH  operand, captured when start is accepted.
REQ-007 shamt  input  SHW  shift amount 0..WIDTH-1, captured when start is accepted.
REQ-008 mode  input  2  shift mode, captured when start is accepted: 00 logical right, 01 logical left, 10 arithmetic right, 11 reserved.
REQ-009 ready  output  1  high only in IDLE; start is accepted only when ready=1.
REQ-010 busy  output  1  high in SHIFT and DONE.
REQ-011 done  output  1  one-cycle pulse; result is valid while done=1.
REQ-012 result  output  WIDTH  shifted value; holds its value until the next accepted start.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 Accept: in IDLE with start=1, the block SHALL latch a into the work register, latch shamt and mode, set the stage index k=SHW-1 and enter SHIFT.
REQ-015 SHIFT: on each edge, the block SHALL apply one fixed stage of 2^k bits, enabled by latched shamt[k], then decrement k (order 16, 8, 4, 2, 1).
- Stage disabled: the work register is unchanged.
REQ-016 Stage enabled, per mode:
- 00: zero-fill right shift by 2^k.
- 01: zero-fill left shift by 2^k.
- 10: right shift by 2^k, with the top 2^k bits filled from bit WIDTH-1 of the current work register.
REQ-017 Mode 11: result SHALL be all-zero once done is asserted, independent of a and shamt.
REQ-018 After the k=0 stage, the block SHALL enter DONE; during DONE, done=1 and result=work register.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 Latency SHALL be fixed regardless of shamt (including shamt=0):
- done is high in the 6th cycle after the cycle in which start was accepted (5 shift edges + 1).
- Back-to-back throughput is one operation per 7 cycles.
REQ-021 start while busy=1 SHALL be ignored, with no effect on state, latched operands or result.
REQ-022 Inputs a, shamt and mode SHALL be ignored except on the accept edge; changing them mid-operation SHALL NOT alter result.
REQ-023 done SHALL never be high for two consecutive cycles.
REQ-024 ready and busy SHALL be mutually exclusive and never both low out of reset.
REQ-025 result SHALL change only on the edge that enters DONE, or on reset.

Reset
REQ-026 With rst=1 at an edge, the block SHALL enter IDLE and clear the work register, result, the latched shamt/mode and k.
REQ-027 After that reset edge: ready=1, busy=0, done=0, result=0.
REQ-028 Reset SHALL take priority over start and over any in-flight operation.
- An aborted operation SHALL never produce done.
- start asserted in the same cycle as rst SHALL be dropped.
REQ-029 The first start SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Logical right: a=0x80000001, shamt=4, mode=00 -> done 6 cycles later; result=0x08000000.
- Arithmetic right: a=0xF0000000, shamt=4, mode=10 -> result=0xFF000000; a=0x80000000, shamt=31, mode=10 -> result=0xFFFFFFFF.
- Left and zero shift: a=0x00000001, shamt=31, mode=01 -> result=0x80000000; a=0x12345678, shamt=0, mode=00 -> result=0x12345678, same latency.
- Reserved mode: a=0xFFFFFFFF, shamt=3, mode=11 -> result=0x00000000.
- Busy rejection: start pulsed every cycle with changing a -> only the first accepted; result matches the first operand; next accept occurs 7 cycles after the first.
- Reset mid-operation: rst for one cycle at the 3rd SHIFT cycle -> no done pulse; result=0; ready=1 on the following cycle.
